mux_sel_pipe: RTL and testbench

- Parametrised, registered N:1 channel selector; successor to the 16:1 inverting mux with force-high blank.
- Generalised to 2^SEL_W channels of DATA_W bits each, with selectable output inversion.
- Adds a valid/ready handshake, a one-stage output register and an auto-scan mode in which an internal counter steps through the channels.
- Sits between the raw input bank and downstream consumers, which can apply backpressure.

---
 rtl/mux_sel_pipe.sv | 118 +++++++++++
 tb/tb_mux_sel_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
// Registered 2^SEL_W:1 channel selector with optional inversion, force-high blank,
// valid/ready handshake and auto-scan counter. Optional out_par port: MUX_SEL_PIPE_PARITY_EN.
module mux_sel_pipe #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 1,
  parameter int INVERT = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [(1<<SEL_W)*DATA_W-1:0]     in_data,
  input  logic [SEL_W-1:0]                 in_sel,
  input  logic                             in_blank,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             scan_mode,
  input  logic                             scan_clr,
  output logic [DATA_W-1:0]                out_data,
  output logic [SEL_W-1:0]                 out_ch,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready
`ifdef MUX_SEL_PIPE_PARITY_EN
  ,
  output logic                             out_par
`endif
);

  localparam int unsigned N = 1 << SEL_W;

  logic [DATA_W-1:0] chan [N];
  logic [SEL_W-1:0]  ch;
  logic [DATA_W-1:0] word;
  logic              accept;

  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      chan[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign ch       = scan_mode ? cnt_q : in_sel;

  always_comb begin
    word = '1;
    if (!in_blank) begin
      word = (INVERT != 0) ? ~chan[ch] : chan[ch];
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (accept) begin
      data_d  = word;
      ch_d    = ch;
      last_d  = scan_mode & (ch == '1);
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Clear takes priority; the accept in the same cycle already consumed the old count.
  always_comb begin
    cnt_d = cnt_q;
    if (scan_clr) begin
      cnt_d = '0;
    end else if (accept && scan_mode) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

`ifdef MUX_SEL_PIPE_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^word;
    end
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: directed scenarios plus randomized traffic
// checked against a behavioural model; out_par checked when MUX_SEL_PIPE_PARITY_EN is set.
module tb_mux_sel_pipe;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 1;
  localparam int INVERT = 1;
  localparam int N      = 1 << SEL_W;
  localparam int NW     = N * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NW-1:0]     in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_blank;
  logic              in_valid;
  logic              in_ready;
  logic              scan_mode;
  logic              scan_clr;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
`ifdef MUX_SEL_PIPE_PARITY_EN
  logic              out_par;
`endif

  mux_sel_pipe #(.SEL_W(SEL_W), .DATA_W(DATA_W), .INVERT(INVERT)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_blank(in_blank),
    .in_valid(in_valid), .in_ready(in_ready), .scan_mode(scan_mode), .scan_clr(scan_clr),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_SEL_PIPE_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                ch;
    bit                last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mv    = 0;
  int   mcnt  = 0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance from its own view of the pipe.
  task automatic drive(input bit v, input int s, input logic [NW-1:0] d,
                       input bit b, input bit sc, input bit cl, input bit r);
    bit   acc;
    int   ch;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_sel = SEL_W'(s); in_data = d; in_blank = b;
    scan_mode = sc; scan_clr = cl; out_ready = r;
    #1;
    check("in_ready", in_ready, (!mv || r));
    acc = v && (!mv || r);
    if (acc) begin
      ch     = sc ? mcnt : s;
      e.data = DATA_W'(d >> (ch * DATA_W));
      if (INVERT != 0) e.data = ~e.data;
      if (b) e.data = '1;
      e.ch   = ch;
      e.last = sc && (ch == N - 1);
      q.push_back(e);
    end
    if (cl) mcnt = 0;
    else if (acc && sc) mcnt = (mcnt + 1) % N;
    mv = acc ? 1'b1 : (r ? 1'b0 : mv);
  endtask

  function automatic logic [NW-1:0] rand_data();
    logic [NW-1:0] d;
    for (int i = 0; i < NW; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // Monitor: every presented word must match the head of the queue; popped on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = q[0];
          check("out_data", out_data, e.data);
          check("out_ch", out_ch, e.ch);
          check("out_last", out_last, e.last);
`ifdef MUX_SEL_PIPE_PARITY_EN
          check("out_par", out_par, ^e.data);
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NW-1:0] ones;
    ones = '1;
    rst_n = 1'b0; in_data = '0; in_sel = '0; in_blank = 0; in_valid = 0;
    scan_mode = 0; scan_clr = 0; out_ready = 0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic select with inversion
    drive(1, 0, NW'(1), 0, 0, 0, 1);
    drive(1, 5, NW'(1), 0, 0, 0, 1);
    // Blank forces all-ones
    drive(1, 3, ones, 1, 0, 0, 1);
    drive(1, 9, '0, 1, 0, 0, 1);
    // Backpressure: accept, then stall with changing inputs, then drain
    drive(1, 2, rand_data(), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, i + 7, rand_data(), 0, 0, 0, 0);
    drive(0, 0, '0, 0, 0, 0, 1);
    drive(0, 0, '0, 0, 0, 0, 1);
    // Full scan with wrap
    drive(0, 0, '0, 0, 1, 1, 1);
    for (int i = 0; i < 17; i++) drive(1, $urandom_range(0, N - 1), rand_data(), 0, 1, 0, 1);
    // Clear coinciding with an accept at count 7
    drive(0, 0, '0, 0, 1, 1, 1);
    for (int i = 0; i < 7; i++) drive(1, 0, rand_data(), 0, 1, 0, 1);
    drive(1, 0, rand_data(), 0, 1, 1, 1);
    drive(1, 0, rand_data(), 0, 1, 0, 1);
    // Mode toggle: counter resumes after manual accepts
    drive(1, 12, rand_data(), 0, 0, 0, 1);
    drive(1, 0, rand_data(), 1, 1, 0, 1);
    drive(0, 0, '0, 0, 0, 0, 1);

    // Async reset while stalled mid-scan
    drive(0, 0, '0, 0, 1, 1, 1);
    for (int i = 0; i < 9; i++) drive(1, 0, rand_data(), 0, 1, 0, 1);
    drive(0, 0, '0, 0, 1, 0, 0);
    drive(0, 0, '0, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    q.delete();
    mv = 0; mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, rand_data(), 0, 1, 0, 1);
    drive(0, 0, '0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, N - 1), rand_data(),
            $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end

    for (int i = 0; i < 3; i++) drive(0, 0, '0, 0, 0, 0, 1);
    @(negedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    check("final_out_valid", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
